// File: rtl/bus_pkg.sv
// Shared decode constants for the bus responder: MMIO register offsets,
// address-region classification and STATUS register bit positions.
package bus_pkg;

    localparam logic [3:0] OFF_TXDATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_CYCLE_LO = 4'h8;
    localparam logic [3:0] OFF_CYCLE_HI = 4'hC;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_NONE
    } region_t;

    localparam int unsigned STAT_OVERFLOW  = 31;
    localparam int unsigned STAT_COUNT_MSB = 15;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_EMPTY     = 0;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO with registered head/valid outputs; a push into
// a full FIFO is accepted when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count_q;
    logic [PW:0]   count_next;
    logic [7:0]    head_q;
    logic          valid_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && valid_q;
    assign full    = (count_q == (PW+1)'(DEPTH));
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_q;
        case ({do_push, do_pop})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is kept in its own register: refill from the next slot on pop,
    // or take the pushed byte when it becomes the new head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_next;
            valid_q <= (count_next != '0);
            if (do_pop && (count_q > (PW+1)'(1))) begin
                head_q <= mem[rd_ptr + 1'b1];
            end else if (do_push && (count_q == '0 || do_pop)) begin
                head_q <= push_data;
            end
        end
    end

    assign head  = head_q;
    assign empty = !valid_q;
    assign count = count_q;

endmodule

// File: rtl/bus_responder.sv
// CPU memory-bus target: byte-writable word RAM plus an MMIO window holding
// a TX byte FIFO, its status register and a 64-bit cycle counter.
module bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned RAM_AW     = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wvalue_i,
  output logic [31:0] rvalue_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       mem [2**RAM_AW];
  region_t           region;
  logic [4:0]        shamt;
  logic [3:0]        lanes;
  logic [31:0]       wdata;
  logic [3:0]        offset;
  logic [RAM_AW-1:0] widx;
  logic              is_read;
  logic              is_write;
  logic              ram_we;
  logic              push;
  logic              pop;
  logic              ovf_clear;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic [63:0]       counter;
  logic [31:0]       shadow;
  logic [31:0]       status;
  logic [31:0]       mmio_rdata;

  always_comb begin
    if (addr_i[31:RAM_AW+2] == '0) begin
      region = REG_RAM;
    end else if (addr_i[31:4] == MMIO_BASE[31:4]) begin
      region = REG_MMIO;
    end else begin
      region = REG_NONE;
    end
  end

  // Initiator sends sub-word data in the low lanes; move it to its byte lane.
  assign shamt  = {addr_i[1:0], 3'b000};
  assign lanes  = wstrb_i << addr_i[1:0];
  assign wdata  = wvalue_i << shamt;
  assign offset = {addr_i[3:2], 2'b00};
  assign widx   = addr_i[RAM_AW+1:2];

  assign is_read   = enable_i && (wstrb_i == '0);
  assign is_write  = enable_i && (wstrb_i != '0);
  assign ram_we    = is_write && (region == REG_RAM) && !rst_i;
  assign push      = is_write && (region == REG_MMIO) && (offset == OFF_TXDATA) && lanes[0];
  assign ovf_clear = is_write && (region == REG_MMIO) && (offset == OFF_STATUS)
                     && lanes[3] && wdata[31];
  assign pop       = tx_valid_o && tx_ready_i;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (push),
    .push_data(wdata[7:0]),
    .pop      (pop),
    .head     (tx_data_o),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign tx_valid_o = !fifo_empty;

  always_comb begin
    status                                = '0;
    status[STAT_OVERFLOW]                 = overflow;
    status[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(fifo_count);
    status[STAT_FULL]                     = fifo_full;
    status[STAT_EMPTY]                    = fifo_empty;
  end

  always_comb begin
    case (offset)
      OFF_STATUS:   mmio_rdata = status;
      OFF_CYCLE_LO: mmio_rdata = counter[31:0];
      OFF_CYCLE_HI: mmio_rdata = shadow;
      default:      mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i]) begin
          mem[widx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalue_o <= '0;
    end else if (is_read) begin
      case (region)
        REG_RAM:  rvalue_o <= mem[widx] >> shamt;
        REG_MMIO: rvalue_o <= mmio_rdata >> shamt;
        default:  rvalue_o <= '0;
      endcase
    end
  end

  // A CYCLE_LO read snapshots the high word so a LO-then-HI pair is coherent.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter  <= '0;
      shadow   <= '0;
      overflow <= 1'b0;
    end else begin
      counter <= counter + 64'd1;
      if (is_read && (region == REG_MMIO) && (offset == OFF_CYCLE_LO)) begin
        shadow <= counter[63:32];
      end
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: RAM alignment, decode, TX FIFO,
// STATUS/overflow, cycle counter snapshot and reset behaviour.
module tb_bus_responder;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wvalue;
    logic [31:0] rvalue;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_responder #(
        .RAM_AW    (10),
        .MMIO_BASE (MB),
        .FIFO_DEPTH(8),
        .INIT_FILE ("")
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable_i  (enable),
        .wstrb_i   (wstrb),
        .addr_i    (addr),
        .wvalue_i  (wvalue),
        .rvalue_o  (rvalue),
        .tx_data_o (tx_data),
        .tx_valid_o(tx_valid),
        .tx_ready_i(tx_ready)
    );

    task automatic idle();
        enable = 1'b0;
        wstrb  = '0;
        addr   = '0;
        wvalue = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        enable = 1'b1;
        addr   = a;
        wstrb  = s;
        wvalue = d;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input logic [31:0] a);
        enable = 1'b1;
        addr   = a;
        wstrb  = '0;
        wvalue = '0;
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr(MB, 4'b0001, 32'h77);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (rvalue !== 32'h0) begin
            errors++;
            $display("FAIL reset_rvalue got %h exp %h", rvalue, 32'h0);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_valid got %b exp 0", tx_valid);
        end
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_status got %h exp %h", rvalue, 32'h1);
        end
    endtask

    task automatic test_ram_word();
        wr(32'h10, 4'b1111, 32'hDEAD_BEEF);
        rd(32'h10);
        checks++;
        if (rvalue !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_word got %h exp %h", rvalue, 32'hDEAD_BEEF);
        end
        rd(32'h13);
        checks++;
        if (rvalue !== 32'h0000_00DE) begin
            errors++;
            $display("FAIL ram_byte3 got %h exp %h", rvalue, 32'hDE);
        end
        wr(32'hFFC, 4'b1111, 32'hA5A5_0001);
        rd(32'hFFC);
        checks++;
        if (rvalue !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL ram_top_word got %h exp %h", rvalue, 32'hA5A5_0001);
        end
    endtask

    task automatic test_ram_bytes();
        wr(32'h11, 4'b0001, 32'h0000_0055);
        rd(32'h10);
        checks++;
        if (rvalue !== 32'hDEAD_55EF) begin
            errors++;
            $display("FAIL ram_sb got %h exp %h", rvalue, 32'hDEAD_55EF);
        end
        wr(32'h13, 4'b0011, 32'h0000_1234);
        rd(32'h10);
        checks++;
        if (rvalue !== 32'h34AD_55EF) begin
            errors++;
            $display("FAIL ram_sh_clip got %h exp %h", rvalue, 32'h34AD_55EF);
        end
        rd(32'h12);
        checks++;
        if (rvalue !== 32'h0000_34AD) begin
            errors++;
            $display("FAIL ram_half_read got %h exp %h", rvalue, 32'h34AD);
        end
    endtask

    task automatic test_unmapped();
        rd(32'h10);
        wr(32'h1010, 4'b1111, 32'h1234_5678);
        repeat (2) @(negedge clk);
        checks++;
        if (rvalue !== 32'h34AD_55EF) begin
            errors++;
            $display("FAIL rvalue_hold got %h exp %h", rvalue, 32'h34AD_55EF);
        end
        rd(32'h10);
        checks++;
        if (rvalue !== 32'h34AD_55EF) begin
            errors++;
            $display("FAIL unmapped_no_alias got %h exp %h", rvalue, 32'h34AD_55EF);
        end
        rd(32'h2000_0000);
        checks++;
        if (rvalue !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_read got %h exp %h", rvalue, 32'h0);
        end
        rd(32'h10);
        rd(MB + 32'h10);
        checks++;
        if (rvalue !== 32'h0) begin
            errors++;
            $display("FAIL past_window_read got %h exp %h", rvalue, 32'h0);
        end
    endtask

    task automatic test_mmio_misc();
        tx_ready = 1'b0;
        wr(MB + 32'h1, 4'b0001, 32'h0000_0099);
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h0000_0001) begin
            errors++;
            $display("FAIL txdata_lane1_no_push got %h exp %h", rvalue, 32'h1);
        end
        rd(MB);
        checks++;
        if (rvalue !== 32'h0) begin
            errors++;
            $display("FAIL txdata_read got %h exp %h", rvalue, 32'h0);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [7:0] exp_b;
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr(MB, 4'b0001, 32'h41 + 32'(i));
        end
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h8000_0802) begin
            errors++;
            $display("FAIL status_overflow got %h exp %h", rvalue, 32'h8000_0802);
        end
        checks++;
        if (tx_data !== 8'h41 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL head_stable got %h/%b exp 41/1", tx_data, tx_valid);
        end
        wr(MB + 32'h4, 4'b1111, 32'h8000_0000);
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h0000_0802) begin
            errors++;
            $display("FAIL status_w1c got %h exp %h", rvalue, 32'h0000_0802);
        end
        // First drain cycle also reads STATUS: it must see the pre-pop state.
        tx_ready = 1'b1;
        enable   = 1'b1;
        addr     = MB + 32'h4;
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'h41 + 8'(i);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
                errors++;
                $display("FAIL drain_%0d got %h/%b exp %h/1", i, tx_data, tx_valid, exp_b);
            end
            @(negedge clk);
            idle();
            if (i == 0) begin
                checks++;
                if (rvalue !== 32'h0000_0802) begin
                    errors++;
                    $display("FAIL status_pre_edge got %h exp %h", rvalue, 32'h0000_0802);
                end
            end
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty got %b exp 0", tx_valid);
        end
        tx_ready = 1'b0;
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h0000_0001) begin
            errors++;
            $display("FAIL status_drained got %h exp %h", rvalue, 32'h1);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q[$];
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(MB, 4'b0001, 32'h61 + 32'(i));
            exp_q.push_back(8'h61 + 8'(i));
        end
        exp_q.push_back(8'h5A);
        checks++;
        if (tx_data !== 8'h61) begin
            errors++;
            $display("FAIL full_head got %h exp %h", tx_data, 8'h61);
        end
        void'(exp_q.pop_front());
        tx_ready = 1'b1;
        wr(MB, 4'b0001, 32'h5A);
        tx_ready = 1'b0;
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h0000_0802) begin
            errors++;
            $display("FAIL full_push_pop_status got %h exp %h", rvalue, 32'h0000_0802);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_q[i]) begin
                errors++;
                $display("FAIL full_drain_%0d got %h/%b exp %h/1", i, tx_data, tx_valid, exp_q[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain_empty got %b exp 0", tx_valid);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_counter();
        @(negedge clk);
        force dut.counter = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.counter;
        rd(MB + 32'h8);
        checks++;
        if (rvalue !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cycle_lo got %h exp %h", rvalue, 32'hFFFF_FFFF);
        end
        rd(MB + 32'hC);
        checks++;
        if (rvalue !== 32'h0) begin
            errors++;
            $display("FAIL cycle_hi_shadow got %h exp %h", rvalue, 32'h0);
        end
        rd(MB + 32'h8);
        checks++;
        if (rvalue !== 32'h0000_0001) begin
            errors++;
            $display("FAIL cycle_lo_wrapped got %h exp %h", rvalue, 32'h1);
        end
        rd(MB + 32'hC);
        checks++;
        if (rvalue !== 32'h0000_0001) begin
            errors++;
            $display("FAIL cycle_hi_carry got %h exp %h", rvalue, 32'h1);
        end
    endtask

    task automatic test_reset_midstream();
        tx_ready = 1'b0;
        wr(MB, 4'b0001, 32'h11);
        wr(MB, 4'b0001, 32'h22);
        wr(MB, 4'b0001, 32'h33);
        rd(32'h10);
        rst    = 1'b1;
        enable = 1'b1;
        addr   = 32'h10;
        wstrb  = '0;
        @(negedge clk);
        rst = 1'b0;
        idle();
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_tx_valid got %b exp 0", tx_valid);
        end
        checks++;
        if (rvalue !== 32'h0) begin
            errors++;
            $display("FAIL midreset_rvalue got %h exp %h", rvalue, 32'h0);
        end
        rd(MB + 32'h4);
        checks++;
        if (rvalue !== 32'h0000_0001) begin
            errors++;
            $display("FAIL midreset_status got %h exp %h", rvalue, 32'h1);
        end
        rd(32'h10);
        checks++;
        if (rvalue !== 32'h34AD_55EF) begin
            errors++;
            $display("FAIL midreset_ram_kept got %h exp %h", rvalue, 32'h34AD_55EF);
        end
    endtask

    initial begin
        rst      = 1'b1;
        tx_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_ram_word();
        test_ram_bytes();
        test_unmapped();
        test_mmio_misc();
        test_fifo_overflow();
        test_full_push_pop();
        test_counter();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
